// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle FSM sequencing the RV64I datapath and memory handshake.
// Optional macro UC_ILLEGAL_TRAP_EN: unknown opcodes trap to ERROR instead of retiring as a NOP.
`default_nettype none

module multicycle_control_unit #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             WE_RF,
  output logic [1:0]       RF_din_sel,
  output logic             ULA_din2_sel,
  output logic             addr_sel,
  output logic             load_pc,
  output logic             load_ir,
  output logic             pc_next_sel,
  output logic             pc_adder_sel,
  output logic [CNT_W-1:0] instret,
  output logic             error,
  output logic [2:0]       state
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

`ifdef UC_ILLEGAL_TRAP_EN
  localparam bit TRAP_ILLEGAL = 1'b1;
`else
  localparam bit TRAP_ILLEGAL = 1'b0;
`endif

  localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (WAIT_LIMIT > 0) ? WAIT_W'(WAIT_LIMIT - 1) : '0;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_ERROR  = 3'd7
  } state_t;

  state_t            cur_state;
  logic [WAIT_W-1:0] wait_cnt;

  logic is_alu_reg, is_alu_imm, is_auipc, is_jal, is_jalr, is_branch;
  logic is_load, is_store, is_mem, is_known, wait_expired;

  assign is_alu_reg = (opcode == OPC_OP) || (opcode == OPC_OP32);
  assign is_alu_imm = (opcode == OPC_IMM) || (opcode == OPC_IMM32) || (opcode == OPC_LUI);
  assign is_auipc   = (opcode == OPC_AUIPC);
  assign is_jal     = (opcode == OPC_JAL);
  assign is_jalr    = (opcode == OPC_JALR);
  assign is_branch  = (opcode == OPC_BRANCH);
  assign is_load    = (opcode == OPC_LOAD);
  assign is_store   = (opcode == OPC_STORE);
  assign is_mem     = is_load || is_store;
  assign is_known   = is_alu_reg || is_alu_imm || is_auipc || is_jal || is_jalr || is_branch || is_mem;

  // Fires on the WAIT_LIMIT-th consecutive cycle without mem_ready.
  assign wait_expired = (WAIT_LIMIT != 0) && !mem_ready && (wait_cnt == WAIT_LAST);

  logic       req_c, mwe_c, we_rf_c, ula2_c, addr_c, ldpc_c, ldir_c, pcn_c, pca_c;
  logic [1:0] rf_c;

  always_comb begin
    req_c   = 1'b0;
    mwe_c   = 1'b0;
    we_rf_c = 1'b0;
    rf_c    = 2'b00;
    ula2_c  = 1'b0;
    addr_c  = 1'b0;
    ldpc_c  = 1'b0;
    ldir_c  = 1'b0;
    pcn_c   = 1'b0;
    pca_c   = 1'b0;
    case (cur_state)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = 1'b1;
        ldir_c = mem_ready;
      end
      S_EXEC: begin
        if (is_alu_reg) begin
          we_rf_c = 1'b1;
          rf_c    = 2'b01;
          ldpc_c  = 1'b1;
        end else if (is_alu_imm) begin
          we_rf_c = 1'b1;
          rf_c    = 2'b01;
          ula2_c  = 1'b1;
          ldpc_c  = 1'b1;
        end else if (is_auipc) begin
          we_rf_c = 1'b1;
          rf_c    = 2'b11;
          ldpc_c  = 1'b1;
        end else if (is_jal) begin
          we_rf_c = 1'b1;
          rf_c    = 2'b10;
          pcn_c   = 1'b1;
          ldpc_c  = 1'b1;
        end else if (is_jalr) begin
          we_rf_c = 1'b1;
          rf_c    = 2'b10;
          pcn_c   = 1'b1;
          pca_c   = 1'b1;
          ula2_c  = 1'b1;
          ldpc_c  = 1'b1;
        end else if (is_branch) begin
          pcn_c  = 1'b1;
          ldpc_c = 1'b1;
        end else if (!is_mem) begin
          ldpc_c = !TRAP_ILLEGAL;
        end
      end
      S_MEM: begin
        req_c  = 1'b1;
        ula2_c = 1'b1;
        mwe_c  = is_store;
        if (mem_ready) begin
          ldpc_c  = 1'b1;
          we_rf_c = is_load;
        end
      end
      default: ;
    endcase
  end

  // Gating by RST_N keeps every strobe low for the whole reset interval.
  assign mem_req      = RST_N & req_c;
  assign mem_we       = RST_N & mwe_c;
  assign WE_RF        = RST_N & we_rf_c;
  assign RF_din_sel   = RST_N ? rf_c : 2'b00;
  assign ULA_din2_sel = RST_N & ula2_c;
  assign addr_sel     = RST_N & addr_c;
  assign load_pc      = RST_N & ldpc_c;
  assign load_ir      = RST_N & ldir_c;
  assign pc_next_sel  = RST_N & pcn_c;
  assign pc_adder_sel = RST_N & pca_c;
  assign state        = cur_state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
      instret   <= '0;
      error     <= 1'b0;
    end else begin
      if (ldpc_c) instret <= instret + CNT_W'(1);
      case (cur_state)
        S_FETCH: begin
          if (mem_ready) begin
            cur_state <= S_DECODE;
          end else if (wait_expired) begin
            cur_state <= S_ERROR;
            error     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: cur_state <= S_EXEC;
        S_EXEC: begin
          wait_cnt <= '0;
          if (is_mem) begin
            cur_state <= S_MEM;
          end else if (TRAP_ILLEGAL && !is_known) begin
            cur_state <= S_ERROR;
            error     <= 1'b1;
          end else begin
            cur_state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            cur_state <= S_FETCH;
            wait_cnt  <= '0;
          end else if (wait_expired) begin
            cur_state <= S_ERROR;
            error     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_ERROR: cur_state <= S_ERROR;
        default: begin
          cur_state <= S_ERROR;
          error     <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: directed per-cycle vectors with hand-computed strobes.
`default_nettype none

module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_we, WE_RF, ULA_din2_sel, addr_sel, load_pc, load_ir;
  logic       pc_next_sel, pc_adder_sel, error;
  logic [1:0] RF_din_sel;
  logic [3:0] instret;
  logic [2:0] state;

  multicycle_control_unit #(.WAIT_LIMIT(4), .CNT_W(4)) dut (
    .CLK(clk), .RST_N(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .WE_RF(WE_RF), .RF_din_sel(RF_din_sel),
    .ULA_din2_sel(ULA_din2_sel), .addr_sel(addr_sel), .load_pc(load_pc),
    .load_ir(load_ir), .pc_next_sel(pc_next_sel), .pc_adder_sel(pc_adder_sel),
    .instret(instret), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;
  localparam logic [6:0] AUI = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] ILL = 7'b0000000;

  typedef struct {
    string       name;
    logic [14:0] vec;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  // {mem_req, mem_we, WE_RF, RF_din_sel, ULA_din2_sel, addr_sel, load_pc, load_ir, pc_next_sel, pc_adder_sel, error, state}
  logic [14:0] act;
  assign act = {mem_req, mem_we, WE_RF, RF_din_sel, ULA_din2_sel, addr_sel,
                load_pc, load_ir, pc_next_sel, pc_adder_sel, error, state};

  function automatic logic [14:0] v(input logic req, input logic mwe, input logic werf,
                                    input logic [1:0] rf, input logic u2, input logic ad,
                                    input logic lp, input logic li, input logic pn,
                                    input logic pa, input logic er, input logic [2:0] st);
    return {req, mwe, werf, rf, u2, ad, lp, li, pn, pa, er, st};
  endfunction

  logic [14:0] IDLE0, FW, FR, DEC, EXN, ERRV;
  initial begin
    IDLE0 = v(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3'd0);
    FW    = v(1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 3'd0);
    FR    = v(1, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 3'd0);
    DEC   = v(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3'd1);
    EXN   = v(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3'd2);
    ERRV  = v(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 3'd7);
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      checks++;
      if (act !== m_e.vec) begin
        errors++;
        $display("FAIL %s strobes got %b expected %b", m_e.name, act, m_e.vec);
      end
      checks++;
      if (instret !== m_e.cnt) begin
        errors++;
        $display("FAIL %s instret got %0d expected %0d", m_e.name, instret, m_e.cnt);
      end
    end
  end

  task automatic step(input string nm, input logic rn, input logic [6:0] op, input logic rdy,
                      input logic [14:0] vec, input logic [3:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rn;
    opcode    = op;
    mem_ready = rdy;
    e.name = nm;
    e.vec  = vec;
    e.cnt  = cnt;
    q.push_back(e);
  endtask

  task automatic simple(input string nm, input logic [6:0] op, input logic [14:0] exec_vec,
                        input logic [3:0] cnt);
    step({nm, "_fetch"},  1, op, 1, FR,       cnt);
    step({nm, "_decode"}, 1, op, 1, DEC,      cnt);
    step({nm, "_exec"},   1, op, 1, exec_vec, cnt);
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; mem_ready = 1'b0;

    step("reset",           0, OP, 0, IDLE0, 4'd0);
    step("fetch_wait",      1, OP, 0, FW,    4'd0);
    step("reset_mid_fetch", 0, OP, 0, IDLE0, 4'd0);
    simple("alu", OP, v(0, 0, 1, 2'b01, 0, 0, 1, 0, 0, 0, 0, 3'd2), 4'd0);

    step("ld_fetch",  1, LD, 1, FR,  4'd1);
    step("ld_decode", 1, LD, 1, DEC, 4'd1);
    step("ld_exec",   1, LD, 1, EXN, 4'd1);
    for (int i = 0; i < 3; i++)
      step("ld_mem_wait", 1, LD, 0, v(1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 3'd3), 4'd1);
    step("ld_mem_ready", 1, LD, 1, v(1, 0, 1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 3'd3), 4'd1);

    step("st_fetch",  1, ST, 1, FR,  4'd2);
    step("st_decode", 1, ST, 1, DEC, 4'd2);
    step("st_exec",   1, ST, 1, EXN, 4'd2);
    step("st_mem",    1, ST, 1, v(1, 1, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 3'd3), 4'd2);

    simple("jalr",   JLR, v(0, 0, 1, 2'b10, 1, 0, 1, 0, 1, 1, 0, 3'd2), 4'd3);
    simple("branch", BR,  v(0, 0, 0, 2'b00, 0, 0, 1, 0, 1, 0, 0, 3'd2), 4'd4);
    simple("jal",    JAL, v(0, 0, 1, 2'b10, 0, 0, 1, 0, 1, 0, 0, 3'd2), 4'd5);
    simple("auipc",  AUI, v(0, 0, 1, 2'b11, 0, 0, 1, 0, 0, 0, 0, 3'd2), 4'd6);

    step("wrap_reset", 0, IMM, 0, IDLE0, 4'd0);
    for (int i = 0; i < 16; i++)
      simple("wrap", IMM, v(0, 0, 1, 2'b01, 1, 0, 1, 0, 0, 0, 0, 3'd2), 4'(i));

    // instret has wrapped back to 0 after 16 retirements
    step("ill_fetch",  1, ILL, 1, FR,  4'd0);
    step("ill_decode", 1, ILL, 1, DEC, 4'd0);
`ifdef UC_ILLEGAL_TRAP_EN
    step("ill_exec",   1, ILL, 1, EXN,  4'd0);
    step("ill_trap",   1, ILL, 1, ERRV, 4'd0);
`else
    step("ill_exec",   1, ILL, 1, v(0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 3'd2), 4'd0);
    step("ill_next",   1, ILL, 1, FR,   4'd1);
`endif

    step("to_reset", 0, OP, 0, IDLE0, 4'd0);
    for (int i = 0; i < 4; i++)
      step("to_wait", 1, OP, 0, FW, 4'd0);
    step("to_error",   1, OP, 0, ERRV,  4'd0);
    step("to_hold",    1, OP, 1, ERRV,  4'd0);
    step("to_hold",    1, OP, 1, ERRV,  4'd0);
    step("to_rst",     0, OP, 1, IDLE0, 4'd0);
    step("to_recover", 1, OP, 1, FR,    4'd0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle FSM that sequences the RV64I datapath (PC, IR, regfile, ULA, immediate decoder).
- Drives every datapath control strobe, runs a req/ready handshake with the unified instruction/data memory, and counts retired instructions.
- Consumes only the datapath's opcode output. Branch-taken is resolved inside the PC unit from the ULA flags.

Parameters:
- WAIT_LIMIT, 255: maximum cycles a memory access may wait for mem_ready before the ERROR state; 0 disables the timeout.
- CNT_W, 64: width of the retired-instruction counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- opcode  in  7  instruction[6:0] from the datapath.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe; valid only with mem_req.
- WE_RF  out  1  regfile write enable.
- RF_din_sel  out  2  regfile source: 00 DM_out, 01 ula, 10 pc+4, 11 pc+imm.
- ULA_din2_sel  out  1  ULA operand 2: 1 imm, 0 rs2.
- addr_sel  out  1  memory address: 1 pc, 0 ula.
- load_pc  out  1  PC load.
- load_ir  out  1  IR load.
- pc_next_sel  out  1  0 = pc+4, 1 = target (conditional for branches, inside the PC unit).
- pc_adder_sel  out  1  secondary adder base: 0 pc, 1 rs1.
- instret  out  CNT_W  retired-instruction count.
- error  out  1  sticky memory timeout / illegal-instruction flag.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (async, RST_N=0): state=FETCH, instret=0, error=0. All strobes are 0 while in reset.
- Default every cycle: all strobes 0, ULA_din2_sel=0, RF_din_sel=00, addr_sel=0.
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, ERROR=7.
- FETCH:
  - addr_sel=1, mem_req=1.
  - While mem_ready=0: hold req and address.
  - On mem_ready=1: load_ir=1, go to DECODE.
- DECODE: one cycle, no strobes. The IR settles and the regfile is read. Next state is EXEC.
- EXEC, by opcode. Every instruction listed here also retires (load_pc=1, instret+1), then goes to FETCH unless noted:
  - OP 0110011 / OP-32 0111011: WE_RF=1, RF_din_sel=01, ULA_din2_sel=0.
  - OP-IMM 0010011 / OP-IMM-32 0011011 / LUI 0110111: WE_RF=1, RF_din_sel=01, ULA_din2_sel=1.
  - AUIPC 0010111: WE_RF=1, RF_din_sel=11, pc_adder_sel=0.
  - JAL 1101111: WE_RF=1, RF_din_sel=10, pc_next_sel=1, pc_adder_sel=0.
  - JALR 1100111: WE_RF=1, RF_din_sel=10, pc_next_sel=1, pc_adder_sel=1, ULA_din2_sel=1.
  - BRANCH 1100011: ULA_din2_sel=0, pc_next_sel=1, pc_adder_sel=0, WE_RF=0.
  - LOAD 0000011 / STORE 0100011: no retire. Go to MEM with no strobes.
  - Any other opcode: see Optional Feature.
- MEM:
  - addr_sel=0, ULA_din2_sel=1, mem_req=1; mem_we=1 for STORE.
  - On mem_ready: retire (load_pc=1, instret+1). LOAD also asserts WE_RF=1 and RF_din_sel=00 in the same cycle.
  - Then go to FETCH.
  - Read data is valid on the mem_ready cycle.
- Wait counter:
  - Cleared on entry to FETCH and MEM; increments each waiting cycle.
  - If WAIT_LIMIT≠0 and the count reaches WAIT_LIMIT with no ready: go to ERROR, error=1.
- ERROR: all strobes 0, held until reset.
- Latency: ALU/jump/branch take 3 cycles with zero-wait memory; load/store take 4.
- instret wraps modulo 2^CNT_W.
- Reset mid-access: mem_req drops immediately (async). No partial regfile/PC write occurs, since writes are gated by CLK in the datapath.
- mem_ready outside FETCH/MEM is ignored.

Optional Feature:
- Macro UC_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in EXEC sets error=1 and enters ERROR; it is not retired.
- Undefined: an unknown opcode is a NOP. load_pc=1 with pc_next_sel=0, instret+1, no WE_RF, back to FETCH.

Test Plan:
- Reset/ALU: RST_N low mid-FETCH, release; opcode 0110011, mem_ready tied 1 → FETCH, DECODE, EXEC; WE_RF=1, RF_din_sel=01, load_pc=1 in cycle 3; instret=1.
- Load with waits: opcode 0000011, mem_ready low 3 cycles in MEM → mem_req held 4 cycles, addr_sel=0; WE_RF=1, RF_din_sel=00, load_pc=1 only on the ready cycle.
- Store/JALR: opcode 0100011 → mem_we=1 in MEM, WE_RF=0. Opcode 1100111 → RF_din_sel=10, pc_adder_sel=1, pc_next_sel=1.
- Timeout: WAIT_LIMIT=4, mem_ready never asserted in FETCH → ERROR after 4 wait cycles, error=1, all strobes 0; recovers only via RST_N.
- Illegal opcode 0000000: with UC_ILLEGAL_TRAP_EN → ERROR, instret unchanged. Without it → load_pc=1, pc_next_sel=0, instret+1.
- Wrap: CNT_W=4, retire 16 OP-IMM instructions → instret returns to 0.
